// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result streamer.
//   ELEM_W / MAX_ELEMS : element width and capacity of the packed result bus
//   ROW_* / COL_*      : bit positions of the rows/cols fields in res_dim
//   stream_state_e     : streamer FSM state encoding
package matrix_pkg;

    localparam int ELEM_W    = 16;
    localparam int MAX_ELEMS = 25;
    localparam int DATA_W    = ELEM_W * MAX_ELEMS;
    localparam int IDX_W     = 5;

    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 3;
    localparam int COL_MSB = 2;
    localparam int COL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_ERR    = 2'd2
    } stream_state_e;

endpackage

// File: rtl/mat_rc_counter.sv
// Row/column position counter for row-major streaming.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force position to (0,0); wins over advance
//   advance    : step one element; col wraps to 0 at cols-1 and row increments
//   rows, cols : dimensions of the result being walked
//   row, col   : current position
//   last       : current position is the final element (rows-1, cols-1)
module mat_rc_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] rows,
    input  logic [2:0] cols,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       col_end;

    assign col_end = (col_q == cols - 3'd1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = 3'd0;
            col_d = 3'd0;
        end else if (advance) begin
            if (col_end) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == rows - 3'd1) && col_end;

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures one finished matrix result and streams it row-major, one element
// per beat, over a valid/ready interface. Failed or malformed results are
// reported as a single error beat.
//   clk, rst_n          : clock, asynchronous active-low reset
//   res_done/res_error  : result strobe and its failure qualifier
//   res_data            : packed elements, element i at [i*ELEM_W +: ELEM_W]
//   res_dim             : [5:3] rows, [2:0] cols
//   busy                : a beat is pending (STREAM or ERR)
//   out_valid/out_ready : beat handshake
//   out_data/row/col    : current element and its position
//   out_last/out_error  : final beat of the result / error token
//   dropped             : a res_done arrived while busy and was ignored
//   dbg_state           : FSM state for observation
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, every out_* signal is held.
module matrix_result_streamer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_done,
    input  logic              res_error,
    input  logic [DATA_W-1:0] res_data,
    input  logic [5:0]        res_dim,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last,
    output logic              out_error,
    output logic              dropped,
    output stream_state_e     dbg_state
);

    stream_state_e     state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [2:0]        rows_q, rows_d;
    logic [2:0]        cols_q, cols_d;

    logic [2:0]        in_rows, in_cols;
    logic [5:0]        in_prod;
    logic              in_invalid;

    logic              cnt_clear, cnt_adv, cnt_last;
    logic [2:0]        cnt_row, cnt_col;
    logic [IDX_W-1:0]  elem_idx;

    logic              accept, accept_end, eval;

    assign in_rows = res_dim[ROW_MSB:ROW_LSB];
    assign in_cols = res_dim[COL_MSB:COL_LSB];
    // 6-bit product so 7x7 cannot wrap below MAX_ELEMS.
    assign in_prod = {3'b000, in_rows} * {3'b000, in_cols};
    assign in_invalid = res_error || (in_rows == 3'd0) || (in_cols == 3'd0)
                        || (in_prod > 6'(MAX_ELEMS));

    assign elem_idx = ({2'b00, cnt_row} * {2'b00, cols_q}) + {2'b00, cnt_col};

    mat_rc_counter u_rc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .rows    (rows_q),
        .cols    (cols_q),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    // Outputs are decoded from registered state so they fall to their
    // reset values the moment rst_n is asserted.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_valid = busy;
        out_error = (state_q == ST_ERR);
        out_last  = out_error || ((state_q == ST_STREAM) && cnt_last);
        out_data  = '0;
        out_row   = 3'd0;
        out_col   = 3'd0;
        if (state_q == ST_STREAM) begin
            out_data = buf_q[int'(elem_idx) * ELEM_W +: ELEM_W];
            out_row  = cnt_row;
            out_col  = cnt_col;
        end
    end

    assign accept     = out_valid && out_ready;
    assign accept_end = accept && out_last;
    // A result arriving on the closing accept is taken as if idle, so the
    // next stream starts without a bubble.
    assign eval       = res_done && ((state_q == ST_IDLE) || accept_end);
    assign dropped    = res_done && busy && !accept_end;
    assign dbg_state  = state_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        if (eval) begin
            cnt_clear = 1'b1;
            if (in_invalid) begin
                state_d = ST_ERR;
            end else begin
                state_d = ST_STREAM;
                buf_d   = res_data;
                rows_d  = in_rows;
                cols_d  = in_cols;
            end
        end else begin
            case (state_q)
                ST_STREAM: begin
                    if (accept) begin
                        if (cnt_last) begin
                            state_d   = ST_IDLE;
                            cnt_clear = 1'b1;
                        end else begin
                            cnt_adv = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    if (accept) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            rows_q  <= 3'd0;
            cols_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;
    import matrix_pkg::*;

    localparam int BEAT_W = 24; // {error, last, row[2:0], col[2:0], data[15:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              res_done = 1'b0;
    logic              res_error = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic [5:0]        res_dim = '0;
    logic              out_ready = 1'b0;
    logic              busy, out_valid, out_last, out_error, dropped;
    logic [ELEM_W-1:0] out_data;
    logic [2:0]        out_row, out_col;
    stream_state_e     dbg_state;

    matrix_result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_done  (res_done),
        .res_error (res_error),
        .res_data  (res_data),
        .res_dim   (res_dim),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_error (out_error),
        .dropped   (dropped),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] cur_beat;
    logic [BEAT_W-1:0] prev_beat = '0;
    logic              prev_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: expand a result into the beats it must produce.
    task automatic push_expected(input logic [2:0] r, input logic [2:0] c,
                                 input logic err, input logic [DATA_W-1:0] d);
        int prod;
        logic last;
        logic [ELEM_W-1:0] e;
        prod = int'(r) * int'(c);
        if (err || r == 3'd0 || c == 3'd0 || prod > MAX_ELEMS) begin
            exp_q.push_back({1'b1, 1'b1, 3'd0, 3'd0, 16'd0});
        end else begin
            for (int i = 0; i < int'(r); i++) begin
                for (int j = 0; j < int'(c); j++) begin
                    last = (i == int'(r) - 1) && (j == int'(c) - 1);
                    e = d[(i * int'(c) + j) * ELEM_W +: ELEM_W];
                    exp_q.push_back({1'b0, last, 3'(i), 3'(j), e});
                end
            end
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            cur_beat = {out_error, out_last, out_row, out_col, out_data};
            if (dropped) drop_cnt++;
            check_eq("busy_eq_valid", {31'd0, busy}, {31'd0, out_valid});
            if (prev_stall) begin
                check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
                check_eq("stall_hold", {8'd0, cur_beat}, {8'd0, prev_beat});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_beat", 32'd1, 32'd0);
                else check_eq("beat", {8'd0, cur_beat}, {8'd0, exp_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur_beat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_result(input logic [2:0] r, input logic [2:0] c, input logic err,
                                input logic [DATA_W-1:0] d, input bit expect_taken);
        res_dim   = {r, c};
        res_error = err;
        res_data  = d;
        res_done  = 1'b1;
        if (expect_taken) push_expected(r, c, err, d);
        @(posedge clk);
        #1;
        res_done  = 1'b0;
        res_error = 1'b0;
    endtask

    // Runs until the scoreboard empties; stall_mode gives out_ready 1,0,0,1,0,0...
    task automatic wait_drain(input int bound, input bit stall_mode);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge clk);
            #1;
            k++;
            if (stall_mode) out_ready = (k % 3 == 0);
        end
        check_eq("drain_timeout", exp_q.size(), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, busy},      32'd0);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_last"},  {31'd0, out_last},  32'd0);
        check_eq({tag, "_error"}, {31'd0, out_error}, 32'd0);
        check_eq({tag, "_drop"},  {31'd0, dropped},   32'd0);
        check_eq({tag, "_data"},  {16'd0, out_data},  32'd0);
        check_eq({tag, "_rowcol"}, {26'd0, out_row, out_col}, 32'd0);
        check_eq({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] d;
        int drop_base;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 2x3, elements 1..6, continuous ready
        d = '0;
        for (int i = 0; i < 6; i++) d[i * ELEM_W +: ELEM_W] = 16'(i + 1);
        drive_result(3'd2, 3'd3, 1'b0, d, 1'b1);
        check_eq("latency_valid", {31'd0, out_valid}, 32'd1);
        wait_drain(20, 1'b0);
        check_eq("busy_after_2x3", {31'd0, busy}, 32'd0);

        // 5x5 full capacity with stalls; last element from the top slice
        for (int i = 0; i < MAX_ELEMS; i++) d[i * ELEM_W +: ELEM_W] = 16'($urandom_range(0, 65535));
        d[399:384] = 16'hBEEF;
        drive_result(3'd5, 3'd5, 1'b0, d, 1'b1);
        wait_drain(200, 1'b1);
        check_eq("busy_after_5x5", {31'd0, busy}, 32'd0);

        // Error beats: explicit error (held while stalled), rows=0, 6x5 over capacity
        out_ready = 1'b0;
        drive_result(3'd2, 3'd2, 1'b1, d, 1'b1);
        wait_drain(20, 1'b1);
        drive_result(3'd0, 3'd3, 1'b0, d, 1'b1);
        wait_drain(20, 1'b0);
        drive_result(3'd6, 3'd5, 1'b0, d, 1'b1);
        wait_drain(20, 1'b0);
        check_eq("busy_after_err", {31'd0, busy}, 32'd0);

        // Second res_done mid-stream is dropped
        for (int i = 0; i < 9; i++) d[i * ELEM_W +: ELEM_W] = 16'h100 + 16'(i);
        drop_base = drop_cnt;
        drive_result(3'd3, 3'd3, 1'b0, d, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive_result(3'd1, 3'd1, 1'b0, {DATA_W{1'b1}}, 1'b0);
        wait_drain(30, 1'b0);
        check_eq("drop_count", drop_cnt - drop_base, 32'd1);

        // Back-to-back: 1x2 arrives on the accept of a 2x2 last beat
        for (int i = 0; i < 4; i++) d[i * ELEM_W +: ELEM_W] = 16'h200 + 16'(i);
        drop_base = drop_cnt;
        drive_result(3'd2, 3'd2, 1'b0, d, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("b2b_last_present", {31'd0, out_last}, 32'd1);
        d = '0;
        d[15:0]  = 16'h3A3A;
        d[31:16] = 16'h4B4B;
        drive_result(3'd1, 3'd2, 1'b0, d, 1'b1);
        check_eq("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        check_eq("b2b_first_data", {16'd0, out_data}, 32'h3A3A);
        wait_drain(20, 1'b0);
        check_eq("b2b_drop", drop_cnt - drop_base, 32'd0);

        // Reset at beat 3 of 4x4, then a fresh 1x1
        for (int i = 0; i < 16; i++) d[i * ELEM_W +: ELEM_W] = 16'h500 + 16'(i);
        drive_result(3'd4, 3'd4, 1'b0, d, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("pre_reset_row_col", {26'd0, out_row, out_col}, {26'd0, 3'd0, 3'd2});
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset_busy", {31'd0, busy}, 32'd0);
        d = '0;
        d[15:0] = 16'h7777;
        drive_result(3'd1, 3'd1, 1'b0, d, 1'b1);
        check_eq("fresh_1x1_last", {31'd0, out_last}, 32'd1);
        wait_drain(20, 1'b0);
        check_eq("busy_after_1x1", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
